traffic_phase_sequencer: RTL and testbench

Consumer end of the 1 Hz timebase. It takes the divided slow clock `clk1` (toggles once per second) as a plain data input, re-times it into the `clk30M` domain and turns every `clk1` edge into a single-cycle second tick. Those ticks drive a six-phase, two-direction traffic-light state machine with a per-phase countdown. The block sits between the frequency divider and the lamp/7-segment drivers.

---
 rtl/traffic_phase_sequencer.sv | 157 +++++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_sequencer.sv
// traffic_phase_sequencer: re-times the 1 Hz timebase into clk30M and
// runs a six-phase two-direction traffic light with a per-phase countdown.
module traffic_phase_sequencer #(
  parameter int unsigned GREEN_SEC   = 25,
  parameter int unsigned YELLOW_SEC  = 3,
  parameter int unsigned ALL_RED_SEC = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk30M,
  input  logic             Reset,
  input  logic             clk1,
  input  logic             hold,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] remain,
  output logic             sec_tick
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_A = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_B = 3'd5
  } state_e;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // A zero duration would stall the countdown, so it is promoted to 1.
  localparam logic [CNT_W-1:0] GREEN_LD =
    (GREEN_SEC == 0) ? CNT_W'(1) : CNT_W'(GREEN_SEC);
  localparam logic [CNT_W-1:0] YELLOW_LD =
    (YELLOW_SEC == 0) ? CNT_W'(1) : CNT_W'(YELLOW_SEC);
  localparam logic [CNT_W-1:0] ALL_RED_LD =
    (ALL_RED_SEC == 0) ? CNT_W'(1) : CNT_W'(ALL_RED_SEC);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic             tick_en;
  logic [2:0]       state_q;
  state_e           state_d;
  logic [CNT_W-1:0] remain_q, remain_d;

  function automatic state_e next_phase(input state_e s);
    state_e n;
    n = ALL_RED_A;
    unique case (s)
      NS_GREEN:  n = NS_YELLOW;
      NS_YELLOW: n = ALL_RED_A;
      ALL_RED_A: n = EW_GREEN;
      EW_GREEN:  n = EW_YELLOW;
      EW_YELLOW: n = ALL_RED_B;
      ALL_RED_B: n = NS_GREEN;
      default:   n = ALL_RED_A;
    endcase
    return n;
  endfunction

  function automatic logic [CNT_W-1:0] phase_len(input state_e s);
    logic [CNT_W-1:0] d;
    d = ALL_RED_LD;
    unique case (s)
      NS_GREEN,
      EW_GREEN:  d = GREEN_LD;
      NS_YELLOW,
      EW_YELLOW: d = YELLOW_LD;
      default:   d = ALL_RED_LD;
    endcase
    return d;
  endfunction

  // Three-stage shift of the slow clock; the last two stages find edges.
  always_comb begin
    s1_d = clk1;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign sec_tick = s2_q ^ s3_q;
  assign tick_en  = sec_tick & ~hold;

  // Synchronizer and edge-detect flops.
  always_ff @(posedge clk30M or posedge Reset) begin
    if (Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  // Phase advance and countdown; undefined codes fall back to all-red.
  always_comb begin
    state_d  = state_e'(state_q);
    remain_d = remain_q;
    unique case (state_q)
      NS_GREEN,
      NS_YELLOW,
      ALL_RED_A,
      EW_GREEN,
      EW_YELLOW,
      ALL_RED_B: begin
        if (tick_en) begin
          if (remain_q <= ONE) begin
            state_d  = next_phase(state_e'(state_q));
            remain_d = phase_len(state_d);
          end else begin
            remain_d = remain_q - ONE;
          end
        end
      end
      default: begin
        state_d  = ALL_RED_A;
        remain_d = ALL_RED_LD;
      end
    endcase
  end

  // Phase state and countdown registers.
  always_ff @(posedge clk30M or posedge Reset) begin
    if (Reset) begin
      state_q  <= NS_GREEN;
      remain_q <= GREEN_LD;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  // Lamp decode straight from the state register; unknown codes show red.
  always_comb begin
    ns_light = LAMP_R;
    ew_light = LAMP_R;
    unique case (state_q)
      NS_GREEN:  ns_light = LAMP_G;
      NS_YELLOW: ns_light = LAMP_Y;
      EW_GREEN:  ew_light = LAMP_G;
      EW_YELLOW: ew_light = LAMP_Y;
      default: begin
        ns_light = LAMP_R;
        ew_light = LAMP_R;
      end
    endcase
  end

  assign remain = remain_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb_traffic_phase_sequencer: directed steps through reset, tick timing,
// a full phase cycle, hold, zero all-red duration and illegal-state recovery.
module tb_traffic_phase_sequencer;

  logic       clk30M = 1'b0;
  logic       Reset  = 1'b0;
  logic       clk1   = 1'b0;
  logic       hold   = 1'b0;
  logic [2:0] ns_light, ew_light;
  logic [7:0] remain;
  logic       sec_tick;
  logic [2:0] dz_ns, dz_ew;
  logic [7:0] dz_remain;
  logic       dz_tick;

  int checks = 0;
  int errors = 0;

  logic [2:0] cur_ns  = 3'b001;
  logic [2:0] cur_ew  = 3'b100;
  logic [7:0] cur_rem = 8'd4;
  bit         dz_chk  = 1'b1;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  traffic_phase_sequencer #(
    .GREEN_SEC(4), .YELLOW_SEC(2), .ALL_RED_SEC(1), .CNT_W(8)
  ) dut (
    .clk30M(clk30M), .Reset(Reset), .clk1(clk1), .hold(hold),
    .ns_light(ns_light), .ew_light(ew_light),
    .remain(remain), .sec_tick(sec_tick)
  );

  traffic_phase_sequencer #(
    .GREEN_SEC(4), .YELLOW_SEC(2), .ALL_RED_SEC(0), .CNT_W(8)
  ) dz (
    .clk30M(clk30M), .Reset(Reset), .clk1(clk1), .hold(hold),
    .ns_light(dz_ns), .ew_light(dz_ew),
    .remain(dz_remain), .sec_tick(dz_tick)
  );

  always #5 clk30M = ~clk30M;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic look(input string tag, input logic [2:0] ns,
                      input logic [2:0] ew, input logic [7:0] rem);
    chk({tag, "_ns"}, 32'(ns_light), 32'(ns));
    chk({tag, "_ew"}, 32'(ew_light), 32'(ew));
    chk({tag, "_remain"}, 32'(remain), 32'(rem));
    chk({tag, "_no_both_green"}, 32'(ns_light[0] & ew_light[0]), 0);
    if (dz_chk) begin
      chk({tag, "_dz_ns"}, 32'(dz_ns), 32'(ns));
      chk({tag, "_dz_ew"}, 32'(dz_ew), 32'(ew));
      chk({tag, "_dz_remain"}, 32'(dz_remain), 32'(rem));
    end
  endtask

  // Called right after the negedge where clk1 (or Reset) changed.
  task automatic observe(input string tag, input bit held,
                         input logic [2:0] ns, input logic [2:0] ew,
                         input logic [7:0] rem);
    @(posedge clk30M); #1;
    chk({tag, "_tick_early"}, 32'(sec_tick), 0);
    @(posedge clk30M); #1;
    chk({tag, "_tick_pulse"}, 32'(sec_tick), 1);
    look({tag, "_pre"}, cur_ns, cur_ew, cur_rem);
    @(posedge clk30M); #1;
    chk({tag, "_tick_width"}, 32'(sec_tick), 0);
    if (held) begin
      look({tag, "_held"}, cur_ns, cur_ew, cur_rem);
    end else begin
      look({tag, "_post"}, ns, ew, rem);
      cur_ns  = ns;
      cur_ew  = ew;
      cur_rem = rem;
    end
    repeat (17) @(posedge clk30M);
  endtask

  task automatic tick(input string tag, input logic [2:0] ns,
                      input logic [2:0] ew, input logic [7:0] rem);
    @(negedge clk30M);
    clk1 = ~clk1;
    observe(tag, 1'b0, ns, ew, rem);
  endtask

  task automatic held_tick(input string tag);
    @(negedge clk30M);
    clk1 = ~clk1;
    observe(tag, 1'b1, cur_ns, cur_ew, cur_rem);
  endtask

  initial begin
    #1 Reset = 1'b1;
    #1;
    look("por", G, R, 8'd4);
    chk("por_tick", 32'(sec_tick), 0);
    repeat (3) @(posedge clk30M);
    @(negedge clk30M);
    Reset = 1'b0;
    repeat (5) @(posedge clk30M);
    #1 look("idle", G, R, 8'd4);

    tick("t_rise", G, R, 8'd3);

    @(negedge clk30M);
    hold = 1'b1;
    held_tick("hold1");
    held_tick("hold2");
    held_tick("hold3");
    @(negedge clk30M);
    hold = 1'b0;

    tick("t_nsg2", G, R, 8'd2);
    tick("t_nsg1", G, R, 8'd1);
    tick("t_nsy2", Y, R, 8'd2);
    tick("t_nsy1", Y, R, 8'd1);
    tick("t_ara",  R, R, 8'd1);
    tick("t_ewg4", R, G, 8'd4);
    tick("t_ewg3", R, G, 8'd3);
    tick("t_ewg2", R, G, 8'd2);
    tick("t_ewg1", R, G, 8'd1);
    tick("t_ewy2", R, Y, 8'd2);
    tick("t_ewy1", R, Y, 8'd1);
    tick("t_arb",  R, R, 8'd1);
    tick("t_wrap", G, R, 8'd4);
    tick("t_nsg3", G, R, 8'd3);
    tick("t_nsg2b", G, R, 8'd2);

    @(negedge clk30M);
    #2 Reset = 1'b1;
    #1;
    look("mid_rst", G, R, 8'd4);
    chk("mid_rst_tick", 32'(sec_tick), 0);
    cur_ns  = G;
    cur_ew  = R;
    cur_rem = 8'd4;
    repeat (3) @(posedge clk30M);
    #1 look("mid_rst_hold", G, R, 8'd4);
    chk("clk1_high_at_release", 32'(clk1), 1);
    @(negedge clk30M);
    Reset = 1'b0;
    observe("rel_high", 1'b0, G, R, 8'd3);

    @(negedge clk30M);
    force dut.state_q = 3'b111;
    #1 release dut.state_q;
    dz_chk = 1'b0;
    @(posedge clk30M); #1;
    look("illegal", R, R, 8'd1);
    cur_ns  = R;
    cur_ew  = R;
    cur_rem = 8'd1;
    repeat (5) @(posedge clk30M);
    tick("t_after_ill", R, G, 8'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
